coriolis_ker1_stream_fifo: RTL and testbench



---
 rtl/coriolis_stream_pkg.sv | 26 ++
 rtl/coriolis_sdp_ram.sv | 34 +++
 rtl/coriolis_ker1_stream_fifo.sv | 111 +++++++++++
 tb/tb_coriolis_ker1_stream_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coriolis_stream_pkg.sv
// Shared definitions for the coriolis_ker1 stream buffers: default stream
// width, FloPoCo exception-field encodings and a constant-safe clog2.
package coriolis_stream_pkg;

  localparam int STREAMW_DEF = 34;

  // FloPoCo exception field, bits [33:32] of a stream word
  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  // Ceiling log2, usable in parameter and port-width expressions
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/coriolis_sdp_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with
// read enable. The read register holds its value while re is low and is
// cleared by rst so the FIFO head output starts at zero.
module coriolis_sdp_ram
  import coriolis_stream_pkg::*;
#(
  parameter int W     = STREAMW_DEF,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage array write; no reset so it maps onto RAM primitives
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read, loaded only when the caller asks for a new word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/coriolis_ker1_stream_fifo.sv
// Elastic first-word-fall-through output buffer for coriolis_ker1 leaf nodes.
//
// Handshake: a word moves upstream->FIFO when ivalid & iready at a rising
// edge, and FIFO->downstream when ovalid & oready at a rising edge. iready,
// afull and ovalid are registers, so no output depends combinationally on
// ivalid or oready.
//
// The head word lives in the RAM read register (out1_s0); count includes it.
// Words still inside the array = count - ovalid; one is moved into the head
// register whenever the head is empty or being popped.
//
// Optional: define CORIOLIS_FIFO_STATS_EN to add hwm and stall_cnt outputs.
module coriolis_ker1_stream_fifo
  import coriolis_stream_pkg::*;
#(
  parameter int STREAMW   = STREAMW_DEF,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ivalid,
  input  logic [STREAMW-1:0]        in1_s0,
  output logic                      iready,
  output logic                      ovalid,
  output logic [STREAMW-1:0]        out1_s0,
  input  logic                      oready,
  output logic                      afull,
  output logic [clog2(DEPTH+1)-1:0] count
`ifdef CORIOLIS_FIFO_STATS_EN
  ,
  output logic [clog2(DEPTH+1)-1:0] hwm,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic [CW-1:0] mem_cnt;
  logic          push;
  logic          pop;
  logic          load;

  assign push = ivalid & iready;
  assign pop  = ovalid & oready;

  // Occupancy bookkeeping and head-prefetch decision
  always_comb begin
    count_next = count;
    mem_cnt    = count - CW'(ovalid);
    load       = (mem_cnt != '0) && (!ovalid || oready);
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally modulo DEPTH; flags are registered from count_next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      iready <= 1'b0;
      afull  <= 1'b0;
      ovalid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      count  <= count_next;
      iready <= (count_next < CW'(DEPTH));
      afull  <= (count_next >= CW'(AFULL_LVL));
      ovalid <= load | (ovalid & ~oready);
    end
  end

  coriolis_sdp_ram #(
    .W     (STREAMW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in1_s0),
    .re    (load),
    .raddr (rd_ptr),
    .rdata (out1_s0)
  );

`ifdef CORIOLIS_FIFO_STATS_EN
  // High-water mark of occupancy and saturating back-pressure cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hwm       <= '0;
      stall_cnt <= '0;
    end else begin
      if (count_next > hwm) hwm <= count_next;
      if (ivalid && !iready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coriolis_ker1_stream_fifo.sv
// Directed + randomized bench for coriolis_ker1_stream_fifo. The reference
// model is a queue of accepted words tagged with their push edge; a word is
// visible once it is the head and at least one further edge has passed.
module tb_coriolis_ker1_stream_fifo;
  import coriolis_stream_pkg::*;

  localparam int W     = 34;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int CW    = clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ivalid = 1'b0;
  logic [W-1:0]  in1_s0 = '0;
  logic          iready;
  logic          ovalid;
  logic [W-1:0]  out1_s0;
  logic          oready = 1'b0;
  logic          afull;
  logic [CW-1:0] count;
`ifdef CORIOLIS_FIFO_STATS_EN
  logic [CW-1:0] hwm;
  logic [31:0]   stall_cnt;
`endif

  coriolis_ker1_stream_fifo #(
    .STREAMW   (W),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ivalid  (ivalid),
    .in1_s0  (in1_s0),
    .iready  (iready),
    .ovalid  (ovalid),
    .out1_s0 (out1_s0),
    .oready  (oready),
    .afull   (afull),
    .count   (count)
`ifdef CORIOLIS_FIFO_STATS_EN
    ,
    .hwm       (hwm),
    .stall_cnt (stall_cnt)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard / reference model state
  logic [W-1:0] exp_q[$];
  int           pcyc_q[$];
  int           cyc;
  logic         m_iready;
  logic         m_ovalid;
  logic [W-1:0] m_last;
  int           m_hwm;
  logic [31:0]  m_stall;
  int           checks = 0;
  int           failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pcyc_q.delete();
    cyc      = 0;
    m_iready = 1'b0;
    m_ovalid = 1'b0;
    m_last   = '0;
    m_hwm    = 0;
    m_stall  = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":count"},  64'(count),  64'(exp_q.size()));
    chk({tag, ":iready"}, 64'(iready), 64'(m_iready));
    chk({tag, ":afull"},  64'(afull),  64'(exp_q.size() >= AFULL));
    chk({tag, ":ovalid"}, 64'(ovalid), 64'(m_ovalid));
    chk({tag, ":data"},   64'(out1_s0), 64'(m_last));
`ifdef CORIOLIS_FIFO_STATS_EN
    chk({tag, ":hwm"},   64'(hwm),       64'(m_hwm));
    chk({tag, ":stall"}, 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // One clock edge: update the model with the handshakes seen at the edge,
  // then compare all outputs 1 time unit later.
  task automatic step(input string tag);
    logic push;
    logic pop;
    push = ivalid && m_iready;
    pop  = oready && m_ovalid;
    if (ivalid && !m_iready && m_stall != 32'hFFFF_FFFF) m_stall++;
    @(posedge clk);
    if (pop) begin
      void'(exp_q.pop_front());
      void'(pcyc_q.pop_front());
    end
    if (push) begin
      exp_q.push_back(in1_s0);
      pcyc_q.push_back(cyc);
    end
    cyc++;
    m_iready = (exp_q.size() < DEPTH);
    m_ovalid = (exp_q.size() > 0) && (pcyc_q[0] <= cyc - 2);
    if (m_ovalid) m_last = exp_q[0];
    if (exp_q.size() > m_hwm) m_hwm = exp_q.size();
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    ivalid = 1'b0;
    oready = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, "_asserted"});
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]  exc;
    logic [31:0] mant;
    int          sent;
    int          budget;

    // Power-on reset
    model_reset();
    #1;
    check_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("rst_release");
    chk("iready_after_release", 64'(iready), 64'd1);

    // Single word through an empty FIFO
    ivalid = 1'b1;
    in1_s0 = 34'h1_3F800000;
    step("single_push");
    chk("single_not_yet_valid", 64'(ovalid), 64'd0);
    ivalid = 1'b0;
    step("single_visible");
    chk("single_ovalid", 64'(ovalid), 64'd1);
    chk("single_data", 64'(out1_s0), 64'h1_3F800000);
    oready = 1'b1;
    step("single_pop");
    chk("single_count0", 64'(count), 64'd0);
    oready = 1'b0;

    // Fill to full with oready low
    for (int i = 0; i < DEPTH; i++) begin
      ivalid = 1'b1;
      in1_s0 = 34'h1_00000000 + 34'(i);
      step("fill");
      if (i == AFULL - 1) chk("afull_at_12", 64'(afull), 64'd1);
      if (i == AFULL - 2) chk("afull_below_12", 64'(afull), 64'd0);
    end
    chk("full_iready", 64'(iready), 64'd0);
    in1_s0 = 34'h3_DEADBEEF;
    step("reject_17th");
    chk("full_reject_count", 64'(count), 64'd16);
    ivalid = 1'b0;

    // Pop at full; iready returns the cycle after, then paired push/pop
    oready = 1'b1;
    ivalid = 1'b1;
    in1_s0 = 34'h2_11111111;
    step("full_pop");
    chk("iready_rerise", 64'(iready), 64'd1);
    step("paired_push_pop");
    oready = 1'b0;
    in1_s0 = 34'h2_22222222;
    step("refill");
    chk("refill_count16", 64'(count), 64'd16);

    // Drain: no bubble while data remains
    ivalid = 1'b0;
    oready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step("drain");
    chk("drain_empty", 64'(count), 64'd0);
    oready = 1'b0;

    // Random stream of 100 words with 50% ivalid/oready
    sent = 0;
    budget = 0;
    while (sent < 100 && budget < 2000) begin
      ivalid = ($urandom_range(0, 1) == 1);
      oready = ($urandom_range(0, 1) == 1);
      exc    = 2'($urandom_range(0, 3));
      mant   = $urandom();
      in1_s0 = {exc, mant};
      if (ivalid && m_iready) sent++;
      step("rand");
      chk("rand_count_bound", 64'(count <= CW'(DEPTH)), 64'd1);
      budget++;
    end
    chk("rand_sent_all", 64'(sent), 64'd100);
    ivalid = 1'b0;
    oready = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      step("rand_drain");
      budget++;
    end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    oready = 1'b0;

    // Mid-stream asynchronous reset discards contents
    for (int i = 0; i < 5; i++) begin
      ivalid = 1'b1;
      in1_s0 = {EXC_NAN, 32'(i * 7 + 3)};
      step("pre_reset_fill");
    end
    async_reset("midstream");
    chk("midstream_out_zero", 64'(out1_s0), 64'd0);
    step("midstream_release");
    chk("midstream_iready", 64'(iready), 64'd1);

    // Stats: ivalid held high for 20 cycles with oready low
`ifdef CORIOLIS_FIFO_STATS_EN
    async_reset("stats");
    step("stats_release");
    ivalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in1_s0 = {EXC_NORMAL, 32'(i)};
      step("stats_hold");
    end
    chk("stats_hwm16", 64'(hwm), 64'd16);
    chk("stats_stall4", 64'(stall_cnt), 64'd4);
    ivalid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
